// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage.
// Holds opcode values, the NOP encoding, the class and state enums, the
// instruction field positions and the immediate/target sign-extend helpers.
package id_pkg;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_R    = 6'h01;
    localparam logic [5:0] OP_I    = 6'h02;
    localparam logic [5:0] OP_LD   = 6'h03;
    localparam logic [5:0] OP_J    = 6'h04;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [31:0] NOP_INSN = {OP_NOP, 26'h0};

    localparam int OP_LSB = 26;
    localparam int RD_LSB = 21;
    localparam int RS_LSB = 16;
    localparam int RT_LSB = 11;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_LD   = 3'd2,
        CLS_J    = 3'd3,
        CLS_NOP  = 3'd4,
        CLS_HALT = 3'd5
    } cls_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    function automatic logic [31:0] sext_imm(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] sext_tgt(input logic [25:0] v);
        return {{6{v[25]}}, v};
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Single-operand forwarding selector.
// Ports: addr (source register), rf_data (register-file read),
//        ex_* / mem_* (in-flight writers), data (selected operand).
// Register 0 always reads zero; a load in EX has no value yet, so it is
// skipped here and handled by the stage's interlock instead.
module id_fwd_mux #(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic [REG_ADDR_LEN-1:0] addr,
    input  logic [WIDTH-1:0]        rf_data,
    input  logic                    ex_wr_en,
    input  logic                    ex_is_load,
    input  logic [REG_ADDR_LEN-1:0] ex_rd,
    input  logic [WIDTH-1:0]        ex_data,
    input  logic                    mem_wr_en,
    input  logic [REG_ADDR_LEN-1:0] mem_rd,
    input  logic [WIDTH-1:0]        mem_data,
    output logic [WIDTH-1:0]        data
);
    always_comb begin
        if (addr == '0)                                   data = '0;
        else if (ex_wr_en && !ex_is_load && ex_rd == addr) data = ex_data;
        else if (mem_wr_en && mem_rd == addr)             data = mem_data;
        else                                              data = rf_data;
    end
endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with valid/ready on both sides.
// Ports: fetch side (in_valid/in_ready/in_ir/in_pc), flush, register-file
//        read port (rf_rd*_addr/rf_rd*_data), EX/MEM forwarding sources,
//        execute side (out_valid/out_ready and decoded out_* fields), halted.
// Decodes, forwards operands, interlocks one cycle on load-use, and holds
// the result in one output register. A run/halt FSM stops intake after HALT.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int PC_W         = WIDTH - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_ir,
    input  logic [PC_W-1:0]         in_pc,
    input  logic                    flush,
    output logic [REG_ADDR_LEN-1:0] rf_rd1_addr,
    output logic [REG_ADDR_LEN-1:0] rf_rd2_addr,
    input  logic [WIDTH-1:0]        rf_rd1_data,
    input  logic [WIDTH-1:0]        rf_rd2_data,
    input  logic                    ex_wr_en,
    input  logic                    ex_is_load,
    input  logic [REG_ADDR_LEN-1:0] ex_rd,
    input  logic [WIDTH-1:0]        ex_data,
    input  logic                    mem_wr_en,
    input  logic [REG_ADDR_LEN-1:0] mem_rd,
    input  logic [WIDTH-1:0]        mem_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_ir,
    output logic [PC_W-1:0]         out_pc,
    output logic [2:0]              out_class,
    output logic [REG_ADDR_LEN-1:0] out_rd,
    output logic [REG_ADDR_LEN-1:0] out_rs,
    output logic [REG_ADDR_LEN-1:0] out_rt,
    output logic [WIDTH-1:0]        out_rs_data,
    output logic [WIDTH-1:0]        out_rt_data,
    output logic [WIDTH-1:0]        out_imm,
    output logic                    halted
);
    logic [5:0]              opcode;
    logic [REG_ADDR_LEN-1:0] rd, rs, rt;
    cls_e                    cls;
    logic                    use_rs, use_rt;
    logic [WIDTH-1:0]        imm;
    logic [WIDTH-1:0]        rs_val, rt_val;
    logic                    hazard, adv, accept;
    state_e                  state;

    logic [1:0][REG_ADDR_LEN-1:0] src_addr;
    logic [1:0][WIDTH-1:0]        src_rf;
    logic [1:0][WIDTH-1:0]        fwd_val;

    assign opcode = in_ir[OP_LSB +: 6];
    assign rd     = in_ir[RD_LSB +: REG_ADDR_LEN];
    assign rs     = in_ir[RS_LSB +: REG_ADDR_LEN];
    assign rt     = in_ir[RT_LSB +: REG_ADDR_LEN];

    assign rf_rd1_addr = rs;
    assign rf_rd2_addr = rt;

    always_comb begin
        cls    = CLS_NOP;
        use_rs = 1'b0;
        use_rt = 1'b0;
        imm    = '0;
        case (opcode)
            OP_R:    begin cls = CLS_R;  use_rs = 1'b1; use_rt = 1'b1; end
            OP_I:    begin cls = CLS_I;  use_rs = 1'b1; imm = WIDTH'($signed(sext_imm(in_ir[15:0]))); end
            OP_LD:   begin cls = CLS_LD; use_rs = 1'b1; imm = WIDTH'($signed(sext_imm(in_ir[15:0]))); end
            OP_J:    begin cls = CLS_J;  imm = WIDTH'($signed(sext_tgt(in_ir[25:0]))); end
            OP_HALT: cls = CLS_HALT;
            OP_NOP:  cls = CLS_NOP;
            default: cls = CLS_NOP;
        endcase
    end

    // Index 0 serves Rs, index 1 serves Rt.
    assign src_addr = {rt, rs};
    assign src_rf   = {rf_rd2_data, rf_rd1_data};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        id_fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_LEN(REG_ADDR_LEN)) u_fwd (
            .addr      (src_addr[g]),
            .rf_data   (src_rf[g]),
            .ex_wr_en  (ex_wr_en),
            .ex_is_load(ex_is_load),
            .ex_rd     (ex_rd),
            .ex_data   (ex_data),
            .mem_wr_en (mem_wr_en),
            .mem_rd    (mem_rd),
            .mem_data  (mem_data),
            .data      (fwd_val[g])
        );
    end

    // I/LD carry the immediate on the Rt operand path.
    assign rs_val = use_rs ? fwd_val[0] : '0;
    assign rt_val = use_rt ? fwd_val[1] :
                    (cls == CLS_I || cls == CLS_LD) ? imm : '0;

    assign hazard = in_valid && ex_is_load && ex_wr_en && (ex_rd != '0) &&
                    ((use_rs && ex_rd == rs) || (use_rt && ex_rd == rt));
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !hazard && (state == ST_RUN) && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            halted      <= 1'b0;
            out_valid   <= 1'b0;
            out_ir      <= WIDTH'(NOP_INSN);
            out_pc      <= '0;
            out_class   <= CLS_NOP;
            out_rd      <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_rs_data <= '0;
            out_rt_data <= '0;
            out_imm     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ir    <= WIDTH'(NOP_INSN);
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_ir      <= in_ir;
            out_pc      <= in_pc;
            out_class   <= cls;
            out_rd      <= rd;
            out_rs      <= rs;
            out_rt      <= rt;
            out_rs_data <= rs_val;
            out_rt_data <= rt_val;
            out_imm     <= imm;
            if (cls == CLS_HALT) begin
                state  <= ST_HALTED;
                halted <= 1'b1;
            end
        end else if (adv) begin
            // Covers the load-use bubble and plain idle cycles.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_ir;
    logic [29:0] in_pc;
    logic        flush;
    logic [4:0]  rf_rd1_addr, rf_rd2_addr;
    logic [31:0] rf_rd1_data, rf_rd2_data;
    logic        ex_wr_en, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        mem_wr_en;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        out_valid, out_ready;
    logic [31:0] out_ir;
    logic [29:0] out_pc;
    logic [2:0]  out_class;
    logic [4:0]  out_rd, out_rs, out_rt;
    logic [31:0] out_rs_data, out_rt_data, out_imm;
    logic        halted;

    id_stage_pipe #(.WIDTH(32), .REG_ADDR_LEN(5), .PC_W(30)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .flush(flush),
        .rf_rd1_addr(rf_rd1_addr), .rf_rd2_addr(rf_rd2_addr),
        .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
        .out_class(out_class), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // External register file model
    logic [31:0] rf [32];
    assign rf_rd1_data = rf[rf_rd1_addr];
    assign rf_rd2_data = rf[rf_rd2_addr];

    typedef struct {
        logic [31:0] ir;
        logic [29:0] pc;
        logic [2:0]  cls;
        logic [31:0] rsd, rtd, imm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'h01, rd, rs, rt, 11'h0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Offer one instruction; push its expected response once it is accepted.
    task automatic send(input logic [31:0] ir, input logic [29:0] pc, input logic [2:0] cls,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm);
        exp_t x;
        bit   done = 0;
        x.ir = ir; x.pc = pc; x.cls = cls; x.rsd = rsd; x.rtd = rtd; x.imm = imm;
        in_valid = 1'b1; in_ir = ir; in_pc = pc;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(x);
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_timeout ir=%h", ir);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output actual_ir=%h required=none", out_ir);
            end else begin
                e = sb.pop_front();
                chk("out_ir", {32'h0, out_ir}, {32'h0, e.ir});
                chk("out_pc", {34'h0, out_pc}, {34'h0, e.pc});
                chk("out_class", {61'h0, out_class}, {61'h0, e.cls});
                chk("out_rd", {59'h0, out_rd}, {59'h0, e.ir[25:21]});
                chk("out_rs", {59'h0, out_rs}, {59'h0, e.ir[20:16]});
                chk("out_rt", {59'h0, out_rt}, {59'h0, e.ir[15:11]});
                chk("out_rs_data", {32'h0, out_rs_data}, {32'h0, e.rsd});
                chk("out_rt_data", {32'h0, out_rt_data}, {32'h0, e.rtd});
                chk("out_imm", {32'h0, out_imm}, {32'h0, e.imm});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; in_ir = 0; in_pc = 0; flush = 0;
        ex_wr_en = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
        mem_wr_en = 0; mem_rd = 0; mem_data = 0; out_ready = 1;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'hDEAD; rf[3] = 10; rf[4] = 20;

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_out_ir", {32'h0, out_ir}, 64'h0);
        chk("rst_out_class", {61'h0, out_class}, 64'h4);
        chk("rst_halted", {63'h0, halted}, 64'h0);
        chk("rst_out_imm", {32'h0, out_imm}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk); #1;

        // Plain R-type from the register file
        send(mk_r(5'd1, 5'd3, 5'd4), 30'h1, 3'd0, 32'd10, 32'd20, 32'h0);
        // EX beats MEM; Rt=r0 reads zero despite rf[0]
        ex_wr_en = 1; ex_rd = 3; ex_data = 32'h55;
        mem_wr_en = 1; mem_rd = 3; mem_data = 32'h66;
        send(mk_r(5'd2, 5'd3, 5'd0), 30'h2, 3'd0, 32'h55, 32'h0, 32'h0);
        ex_wr_en = 0;
        send(mk_r(5'd2, 5'd3, 5'd0), 30'h3, 3'd0, 32'h66, 32'h0, 32'h0);

        // Load-use interlock: one stall cycle then MEM forwarding
        mem_wr_en = 0;
        ex_wr_en = 1; ex_is_load = 1; ex_rd = 4; ex_data = 32'hBAD0;
        in_valid = 1; in_ir = mk_r(5'd5, 5'd3, 5'd4); in_pc = 30'h4;
        @(negedge clk);
        chk("hazard_in_ready", {63'h0, in_ready}, 64'h0);
        @(posedge clk); #1;
        chk("hazard_bubble", {63'h0, out_valid}, 64'h0);
        ex_wr_en = 0; ex_is_load = 0;
        mem_wr_en = 1; mem_rd = 4; mem_data = 32'h77;
        send(mk_r(5'd5, 5'd3, 5'd4), 30'h4, 3'd0, 32'd10, 32'h77, 32'h0);
        mem_wr_en = 0;

        // Backpressure: held output must not move or re-forward
        send(mk_r(5'd6, 5'd5, 5'd6), 30'h5, 3'd0, 32'h105, 32'h106, 32'h0);
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; in_ir = mk_i(6'h02, 5'd7, 5'd3, 16'h8000); in_pc = 30'h6;
            ex_wr_en = 1; ex_rd = 5; ex_data = 32'h999;
            @(negedge clk);
            chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
            chk("bp_out_ir", {32'h0, out_ir}, {32'h0, mk_r(5'd6, 5'd5, 5'd6)});
            chk("bp_out_rs_data", {32'h0, out_rs_data}, 64'h105);
            @(posedge clk); #1;
        end
        ex_wr_en = 0; out_ready = 1;

        // Sign extension and class handling
        send(mk_i(6'h02, 5'd7, 5'd3, 16'h8000), 30'h6, 3'd1, 32'd10, 32'hFFFF8000, 32'hFFFF8000);
        mem_wr_en = 1; mem_rd = 0; mem_data = 32'hBAD;
        send(mk_i(6'h03, 5'd8, 5'd0, 16'h0004), 30'h7, 3'd2, 32'h0, 32'h4, 32'h4);
        mem_wr_en = 0;
        send({6'h04, 26'h2000000}, 30'h8, 3'd3, 32'h0, 32'h0, 32'hFE000000);
        send(32'h0, 30'h9, 3'd4, 32'h0, 32'h0, 32'h0);

        // Flush squashes the held instruction and the offered one
        send(mk_r(5'd9, 5'd4, 5'd3), 30'hA, 3'd0, 32'd20, 32'd10, 32'h0);
        out_ready = 0;
        in_valid = 1; in_ir = mk_r(5'd10, 5'd3, 5'd3); in_pc = 30'hB; flush = 1;
        @(negedge clk);
        chk("flush_in_ready", {63'h0, in_ready}, 64'h0);
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        void'(sb.pop_back());
        chk("flush_out_valid", {63'h0, out_valid}, 64'h0);
        chk("flush_out_ir", {32'h0, out_ir}, 64'h0);
        @(negedge clk);
        chk("flush_no_accept", {63'h0, out_valid}, 64'h0);
        @(posedge clk); #1;
        out_ready = 1;

        // HALT, then stuck until reset
        send({6'h3F, 26'h0}, 30'h20, 3'd5, 32'h0, 32'h0, 32'h0);
        chk("halted_set", {63'h0, halted}, 64'h1);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; in_ir = mk_r(5'd1, 5'd4, 5'd4); in_pc = 30'h21;
            flush = (c == 1);
            @(negedge clk);
            chk("halt_in_ready", {63'h0, in_ready}, 64'h0);
            chk("halt_halted", {63'h0, halted}, 64'h1);
            @(posedge clk); #1;
        end
        flush = 0; in_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rerst_halted", {63'h0, halted}, 64'h0);
        chk("rerst_out_valid", {63'h0, out_valid}, 64'h0);
        @(negedge clk);
        chk("rerst_in_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk); #1;
        send(mk_r(5'd1, 5'd4, 5'd4), 30'h22, 3'd0, 32'd20, 32'd20, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", {32'h0, 32'(sb.size())}, 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
